muldiv_unit: RTL

Iterative multiply/divide unit for the multicycle MIPS datapath. Consumes the two register-file read operands (rs, rt) for MULT/MULTU/DIV/DIVU and produces the architectural HI/LO pair read back by MFHI/MFLO. It runs one shift-add / restoring-subtract step per clock and reports completion through a start/busy/done handshake to the control FSM.

---
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit producing architectural HI/LO, one step per clock.
// Define MULDIV_DIV_EN to build the restoring divider; without it DIV/DIVU complete at once with HI/LO untouched.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hiWrite,
  input  logic             loWrite,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [1:0]       op_q;
  logic             res_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [PW-1:0]    work, work_step;
  logic [WIDTH:0]   upper_add;
`ifdef MULDIV_DIV_EN
  logic             rem_neg;
  logic [PW-1:0]    shifted;
  logic [WIDTH:0]   trial;
`endif

  function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] x,
                                             input logic is_signed);
    abs_w = (is_signed && x[WIDTH-1]) ? WIDTH'(-x) : x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] x, input logic neg);
    cond_neg_w = neg ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] x,
                                                     input logic neg);
    cond_neg_2w = neg ? (~x + (2*WIDTH)'(1)) : x;
  endfunction

  assign busy  = (state != IDLE);
  assign a_abs = abs_w(srcA, !op[0]);
  assign b_abs = abs_w(srcB, !op[0]);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MULDIV_DIV_EN
          state_nxt = RUN;
`else
          state_nxt = op[1] ? FIX : RUN;
`endif
        end
      end
      RUN:     if (count == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Multiply: accumulate multiplicand into the upper half, then shift the whole product right.
  // Divide: shift {remainder, quotient} left and keep the trial subtraction when it does not borrow.
  always_comb begin
    upper_add = work[PW-1:WIDTH] + (work[0] ? {1'b0, a_mag} : {(WIDTH+1){1'b0}});
    work_step = {1'b0, upper_add, work[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    shifted = {work[PW-2:0], 1'b0};
    trial   = shifted[PW-1:WIDTH] - {1'b0, b_mag};
    if (op_q[1]) begin
      if (shifted[PW-1:WIDTH] >= {1'b0, b_mag})
        work_step = {trial, shifted[WIDTH-1:1], 1'b1};
      else
        work_step = shifted;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= '0;
      op_q      <= '0;
      res_neg   <= 1'b0;
      a_mag     <= '0;
      b_mag     <= '0;
      work      <= '0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      divByZero <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem_neg   <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      divByZero <= 1'b0;
      case (state)
        IDLE: begin
          if (hiWrite) hi <= srcA;
          if (loWrite) lo <= srcA;
          if (start) begin
            op_q    <= op;
            a_mag   <= a_abs;
            b_mag   <= b_abs;
            res_neg <= !op[0] && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
            count   <= CW'(WIDTH);
            // Low half seeds the multiplier for MULT*, the dividend for DIV*.
            work    <= {{(WIDTH+1){1'b0}}, op[1] ? a_abs : b_abs};
`ifdef MULDIV_DIV_EN
            rem_neg <= !op[0] && srcA[WIDTH-1];
`endif
          end
        end
        RUN: begin
          work  <= work_step;
          count <= count - CW'(1);
        end
        FIX: begin
          done <= 1'b1;
          if (!op_q[1]) begin
            {hi, lo} <= cond_neg_2w(work[2*WIDTH-1:0], res_neg);
          end
`ifdef MULDIV_DIV_EN
          else begin
            lo        <= cond_neg_w(work[WIDTH-1:0], res_neg);
            hi        <= cond_neg_w(work[2*WIDTH-1:WIDTH], rem_neg);
            divByZero <= (b_mag == '0);
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
